// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch lookup,
// combinational mispredict/redirect resolution, and clocked update from execute.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_jal,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid_reg;
  logic [1:0]          ctr_reg    [ENTRIES];
  logic [TAG_BITS-1:0] tag_reg    [ENTRIES];
  logic [29:0]         target_reg [ENTRIES];
  logic [31:0]         branches_reg;
  logic [31:0]         mispredicts_reg;

  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic [TAG_BITS-1:0]   ex_tag;
  logic                  if_hit;
  logic                  ex_hit;
  logic                  wr_en;
  logic                  tgt_wr;
  logic [1:0]            ctr_next;
  logic                  unused_bits;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[31:INDEX_BITS+2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_tag = ex_pc[31:INDEX_BITS+2];
  assign unused_bits = &{1'b0, if_pc[1:0]};

  assign if_hit = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
  assign ex_hit = valid_reg[ex_idx] && (tag_reg[ex_idx] == ex_tag);

  // Prediction is suppressed while reset is held so stale entries never leak out.
  assign pred_taken  = !rst && if_hit && ctr_reg[if_idx][1];
  assign pred_target = pred_taken ? {target_reg[if_idx], 2'b00} : 32'd0;

  assign mispredict = ex_valid &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = !mispredict ? 32'd0 :
                       (ex_taken ? ex_target : ex_pc + 32'd4);

  assign stat_branches    = branches_reg;
  assign stat_mispredicts = mispredicts_reg;

  always_comb begin
    wr_en    = 1'b0;
    tgt_wr   = 1'b0;
    ctr_next = ctr_reg[ex_idx];
    if (ex_valid) begin
      if (ex_is_jal) begin
        wr_en    = 1'b1;
        tgt_wr   = 1'b1;
        ctr_next = 2'b11;
      end else if (ex_hit) begin
        wr_en  = 1'b1;
        tgt_wr = ex_taken;
        if (ex_taken)
          ctr_next = (ctr_reg[ex_idx] == 2'b11) ? 2'b11 : ctr_reg[ex_idx] + 2'd1;
        else
          ctr_next = (ctr_reg[ex_idx] == 2'b00) ? 2'b00 : ctr_reg[ex_idx] - 2'd1;
      end else if (ex_taken) begin
        // Taken miss allocates, evicting whatever aliased into this slot.
        wr_en    = 1'b1;
        tgt_wr   = 1'b1;
        ctr_next = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg       <= '0;
      branches_reg    <= 32'd0;
      mispredicts_reg <= 32'd0;
      for (int i = 0; i < ENTRIES; i++)
        ctr_reg[i] <= 2'b01;
    end else begin
      if (wr_en) begin
        valid_reg[ex_idx] <= 1'b1;
        ctr_reg[ex_idx]   <= ctr_next;
      end
      if (ex_valid)
        branches_reg <= branches_reg + 32'd1;
      if (mispredict)
        mispredicts_reg <= mispredicts_reg + 32'd1;
    end
  end

  // Tag/target payload needs no reset; valid_reg gates every use of it.
  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      tag_reg[ex_idx] <= ex_tag;
    if (!rst && tgt_wr)
      target_reg[ex_idx] <= ex_target[31:2];
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;
  localparam int IB = 6;
  localparam int NE = 1 << IB;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_jal;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_predictor #(.INDEX_BITS(IB)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_jal(ex_is_jal), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_taken(ex_taken),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] rpc;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model: one record per BTB slot, stored as plain PC-level values.
  bit          m_valid [NE];
  logic [31:0] m_tag   [NE];
  logic [31:0] m_tgt   [NE];
  int          m_ctr   [NE];
  logic [31:0] m_sb, m_sm;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc >> (IB + 2);
  endfunction

  function automatic logic m_predict(logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_sb = 0;
    m_sm = 0;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d: got %h expected %h", name, txn, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [31:0] ipc, input logic ev,
                       input logic jal, input logic [31:0] epc, input logic [31:0] etgt,
                       input logic tk, input logic ptk, input logic [31:0] ptgt);
    exp_t e;
    int   i;
    logic hit;
    @(posedge clk);
    #1;
    rst = r; if_pc = ipc; ex_valid = ev; ex_is_jal = jal; ex_pc = epc;
    ex_target = etgt; ex_taken = tk; ex_pred_taken = ptk; ex_pred_target = ptgt;

    e.pt  = !r && m_predict(ipc);
    e.ptg = e.pt ? m_tgt[idx_of(ipc)] : 32'd0;
    e.mp  = ev && ((tk != ptk) || (tk && ptk && etgt != ptgt));
    e.rpc = e.mp ? (tk ? etgt : epc + 32'd4) : 32'd0;
    e.sb  = m_sb;
    e.sm  = m_sm;
    q.push_back(e);

    // Effect of the coming clock edge.
    if (r) begin
      model_reset();
    end else if (ev) begin
      i   = idx_of(epc);
      hit = m_valid[i] && (m_tag[i] == tag_of(epc));
      if (jal) begin
        m_valid[i] = 1'b1; m_tag[i] = tag_of(epc); m_tgt[i] = etgt & ~32'd3; m_ctr[i] = 3;
      end else if (hit) begin
        m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (tk) m_tgt[i] = etgt & ~32'd3;
      end else if (tk) begin
        m_valid[i] = 1'b1; m_tag[i] = tag_of(epc); m_tgt[i] = etgt & ~32'd3; m_ctr[i] = 2;
      end
      m_sb = m_sb + 32'd1;
      if (e.mp) m_sm = m_sm + 32'd1;
    end
  endtask

  // Monitor: outputs are combinational, so one expectation is due every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        txn++;
        chk("pred_taken", 32'(pred_taken), 32'(e.pt));
        chk("pred_target", pred_target, e.ptg);
        chk("mispredict", 32'(mispredict), 32'(e.mp));
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("stat_branches", stat_branches, e.sb);
        chk("stat_mispredicts", stat_mispredicts, e.sm);
        $display("txn %0d: if_pc=%h pt=%0b ptgt=%h mp=%0b rpc=%h sb=%0d sm=%0d",
                 txn, if_pc, pred_taken, pred_target, mispredict, redirect_pc,
                 stat_branches, stat_mispredicts);
      end
    end
  end

  initial begin
    logic [31:0] pc_a, pc_b, tgt, ptgt;
    logic        jal, tk, ptk, ev;
    int          wait_cnt;

    rst = 1'b1; if_pc = 0; ex_valid = 0; ex_is_jal = 0; ex_pc = 0;
    ex_target = 0; ex_taken = 0; ex_pred_taken = 0; ex_pred_target = 0;
    model_reset();
    repeat (3) @(posedge clk);

    // Directed sequence.
    cycle(0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0);
    cycle(0, 32'h100, 1, 0, 32'h100, 32'h80,  1, 0, 32'h0);
    cycle(0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0);
    cycle(0, 32'h100, 1, 0, 32'h100, 32'h80,  0, 1, 32'h80);
    cycle(0, 32'h100, 1, 0, 32'h100, 32'h80,  0, 0, 32'h0);
    cycle(0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0);
    for (int k = 0; k < 5; k++)
      cycle(0, 32'h100, 1, 0, 32'h100, 32'h80, 1, 1, 32'h80);
    cycle(0, 32'h100, 1, 0, 32'h100, 32'h80,  0, 1, 32'h80);
    cycle(0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0);
    cycle(0, 32'h200, 1, 1, 32'h200, 32'h400, 1, 1, 32'h300);
    cycle(0, 32'h200, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0);
    cycle(0, 32'h100, 1, 0, 32'h100, 32'h80,  1, 0, 32'h0);
    cycle(0, 32'h100, 1, 0, 32'h200, 32'h500, 0, 0, 32'h0);
    cycle(0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0);
    cycle(0, 32'h100, 1, 0, 32'h200, 32'h500, 1, 0, 32'h0);
    cycle(0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0);
    cycle(1, 32'h300, 1, 0, 32'h300, 32'h600, 1, 0, 32'h0);
    cycle(0, 32'h300, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0);
    cycle(0, 32'h200, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0);
    cycle(0, 32'h300, 1, 0, 32'h300, 32'h600, 1, 0, 32'h0);
    cycle(0, 32'h300, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0);
    cycle(0, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 32'h40, 0, 1, 32'h40);

    // Randomized traffic over a small PC pool so hits, aliases and saturation recur.
    for (int n = 0; n < 500; n++) begin
      pc_a = (32'($urandom_range(0, 2)) << (IB + 2)) | (32'($urandom_range(0, 3)) << 2);
      pc_b = ($urandom_range(0, 3) == 0) ? pc_a
             : ((32'($urandom_range(0, 2)) << (IB + 2)) | (32'($urandom_range(0, 3)) << 2));
      ev   = ($urandom_range(0, 4) != 0);
      jal  = ($urandom_range(0, 4) == 0);
      tk   = jal ? 1'b1 : 1'($urandom_range(0, 1));
      tgt  = 32'($urandom_range(1, 8)) << 2;
      if ($urandom_range(0, 1) == 0) begin
        ptk  = m_predict(pc_a);
        ptgt = ptk ? m_tgt[idx_of(pc_a)] : 32'd0;
      end else begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = 32'($urandom_range(1, 8)) << 2;
      end
      cycle(($urandom_range(0, 60) == 0), pc_b, ev, jal, pc_a, tgt, tk, ptk, ptgt);
    end

    @(posedge clk);
    #1;
    ex_valid = 0;
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
